// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Brief    : Shared widths, zero-register index, queue entry and grant types
//            for the register-file write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    typedef enum logic {
        GRANT_WB0 = 1'b0,
        GRANT_WB1 = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter_if
// Brief    : Writeback request ports, register-file write port and busy mask.
// Revision : 1.0 - initial release
// ============================================================================
interface rf_write_arbiter_if;
    import rf_pkg::*;

    logic                  wb0_valid;
    logic [REG_ADDR_W-1:0] wb0_addr;
    logic [DATA_W-1:0]     wb0_data;
    logic                  wb0_ready;
    logic                  wb1_valid;
    logic [REG_ADDR_W-1:0] wb1_addr;
    logic [DATA_W-1:0]     wb1_data;
    logic                  wb1_ready;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic [NUM_REGS-1:0]   busy;

    modport master (
        output wb0_valid, wb0_addr, wb0_data,
        output wb1_valid, wb1_addr, wb1_data,
        input  wb0_ready, wb1_ready,
        input  rf_we, rf_waddr, rf_wdata, busy
    );

    modport slave (
        input  wb0_valid, wb0_addr, wb0_data,
        input  wb1_valid, wb1_addr, wb1_data,
        output wb0_ready, wb1_ready,
        output rf_we, rf_waddr, rf_wdata, busy
    );

endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Brief    : Per-requester write queue; exposes slot addresses and validity
//            so the parent can build the pending-write mask.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  wire logic      clk,
    input  wire logic      reset,
    input  wire logic      i_push,
    input  wire wb_entry_t i_entry,
    input  wire logic      i_pop,
    output wb_entry_t      o_head,
    output logic           o_full,
    output logic           o_empty,
    output logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] o_slot_addr,
    output logic [FIFO_DEPTH-1:0]                 o_slot_valid
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = 1;
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);

    logic [c_PTR_W-1:0]        r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0]        r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0]        r_count_q, w_count_d;
    wb_entry_t [FIFO_DEPTH-1:0] r_mem_q, w_mem_d;

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (i_push) begin
            w_mem_d[r_wr_ptr_q] = i_entry;
            w_wr_ptr_d          = r_wr_ptr_q + c_PTR_ONE;
        end
        if (i_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_ONE;
        end
        case ({i_push, i_pop})
            2'b10:   w_count_d = r_count_q + c_CNT_ONE;
            2'b01:   w_count_d = r_count_q - c_CNT_ONE;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_q    <= '0;
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_mem_q    <= w_mem_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    assign o_head  = r_mem_q[r_rd_ptr_q];
    assign o_full  = (r_count_q == c_CNT_FULL);
    assign o_empty = (r_count_q == '0);

    // A slot is live when its distance past the read pointer is below the occupancy.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            localparam logic [c_PTR_W-1:0] c_SLOT = c_PTR_W'(gi);
            logic [c_PTR_W-1:0] w_offset;
            assign w_offset         = c_SLOT - r_rd_ptr_q;
            assign o_slot_valid[gi] = ({1'b0, w_offset} < r_count_q);
            assign o_slot_addr[gi]  = r_mem_q[gi].addr;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Brief    : Merges two writeback streams into one register-file write port
//            with round-robin arbitration and a pending-write busy mask.
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    rf_write_arbiter_if.slave bus
);

    logic                  r_run_q;
    logic                  r_rf_we_q, w_rf_we_d;
    logic [REG_ADDR_W-1:0] r_rf_waddr_q, w_rf_waddr_d;
    logic [DATA_W-1:0]     r_rf_wdata_q, w_rf_wdata_d;
    grant_t                r_last_grant_q, w_last_grant_d;

    wb_entry_t w_entry0, w_entry1, w_head0, w_head1;
    logic      w_push0, w_push1, w_pop0, w_pop1;
    logic      w_full0, w_full1, w_empty0, w_empty1;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] w_slot_addr0, w_slot_addr1;
    logic [FIFO_DEPTH-1:0]                 w_slot_valid0, w_slot_valid1;
    logic [NUM_REGS-1:0]   w_busy;

    // Ready waits for one edge after reset release so it never rises asynchronously.
    assign bus.wb0_ready = r_run_q & ~w_full0;
    assign bus.wb1_ready = r_run_q & ~w_full1;

    // Zero-register writes complete the handshake but never enter a queue.
    assign w_push0 = bus.wb0_valid & bus.wb0_ready & (bus.wb0_addr != REG_ZERO);
    assign w_push1 = bus.wb1_valid & bus.wb1_ready & (bus.wb1_addr != REG_ZERO);

    assign w_entry0 = '{addr: bus.wb0_addr, data: bus.wb0_data};
    assign w_entry1 = '{addr: bus.wb1_addr, data: bus.wb1_data};

    wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push0),
        .i_entry      (w_entry0),
        .i_pop        (w_pop0),
        .o_head       (w_head0),
        .o_full       (w_full0),
        .o_empty      (w_empty0),
        .o_slot_addr  (w_slot_addr0),
        .o_slot_valid (w_slot_valid0)
    );

    wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push1),
        .i_entry      (w_entry1),
        .i_pop        (w_pop1),
        .o_head       (w_head1),
        .o_full       (w_full1),
        .o_empty      (w_empty1),
        .o_slot_addr  (w_slot_addr1),
        .o_slot_valid (w_slot_valid1)
    );

    always_comb begin
        w_pop0         = 1'b0;
        w_pop1         = 1'b0;
        w_rf_waddr_d   = r_rf_waddr_q;
        w_rf_wdata_d   = r_rf_wdata_q;
        w_last_grant_d = r_last_grant_q;
        if (!w_empty0 && (w_empty1 || r_last_grant_q == GRANT_WB1)) begin
            w_pop0         = 1'b1;
            w_rf_waddr_d   = w_head0.addr;
            w_rf_wdata_d   = w_head0.data;
            w_last_grant_d = GRANT_WB0;
        end else if (!w_empty1) begin
            w_pop1         = 1'b1;
            w_rf_waddr_d   = w_head1.addr;
            w_rf_wdata_d   = w_head1.data;
            w_last_grant_d = GRANT_WB1;
        end
        w_rf_we_d = w_pop0 | w_pop1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run_q        <= 1'b0;
            r_rf_we_q      <= 1'b0;
            r_rf_waddr_q   <= REG_ZERO;
            r_rf_wdata_q   <= '0;
            r_last_grant_q <= GRANT_WB1;
        end else begin
            r_run_q        <= 1'b1;
            r_rf_we_q      <= w_rf_we_d;
            r_rf_waddr_q   <= w_rf_waddr_d;
            r_rf_wdata_q   <= w_rf_wdata_d;
            r_last_grant_q <= w_last_grant_d;
        end
    end

    // Every queued entry plus the write currently on the port is still pending.
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_slot_valid0[i]) w_busy[w_slot_addr0[i]] = 1'b1;
            if (w_slot_valid1[i]) w_busy[w_slot_addr1[i]] = 1'b1;
        end
        if (r_rf_we_q) w_busy[r_rf_waddr_q] = 1'b1;
        w_busy[REG_ZERO] = 1'b0;
    end

    assign bus.rf_we    = r_rf_we_q;
    assign bus.rf_waddr = r_rf_waddr_q;
    assign bus.rf_wdata = r_rf_wdata_q;
    assign bus.busy     = w_busy;

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 2, meaning entries per requester queue (power of two, ≥2).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have ports wb0_valid, wb1_valid  input  1 each  write request from requester 0 (pipeline writeback) and requester 1 (multicycle unit).
REQ-005 The block SHALL have ports wb0_addr, wb1_addr  input  5 each  destination register index.
REQ-006 The block SHALL have ports wb0_data, wb1_data  input  32 each  write data.
REQ-007 The block SHALL have ports wb0_ready, wb1_ready  output  1 each  queue can accept a request this cycle.
REQ-008 The block SHALL have port rf_we  output  1  register-file write enable (drives RegWrite).
REQ-009 The block SHALL have port rf_waddr  output  5  drives Write_Register.
REQ-010 The block SHALL have port rf_wdata  output  32  drives Write_Data.
REQ-011 The block SHALL have port busy  output  32  per-register pending-write mask for the hazard unit.

Function
REQ-012 Request on port k SHALL be accepted at a posedge where wbk_valid and wbk_ready are both 1; accepted entry pushed to queue k.
REQ-013 wbk_ready SHALL equal "queue k not full", derived from registered occupancy only; no combinational path from any valid to any ready.
REQ-014 Each posedge, at most one queue head SHALL be popped and registered into rf_we/rf_waddr/rf_wdata; rf_we SHALL be high exactly one cycle per pop, low otherwise.
REQ-015 Arbitration SHALL be round-robin: only one queue non-empty -> pop it; both non-empty -> pop the queue not granted last; last-grant register updates only on a pop.
REQ-016 Minimum latency SHALL be 2 edges: accepted at edge N, popped at edge N+1, rf_we high during cycle N+1..N+2 so the negedge-written register file captures it mid-cycle.
REQ-017 Push and pop on the same queue in the same edge SHALL both take effect; occupancy unchanged; a full queue popped this edge still shows ready=0 this cycle.
REQ-018 Per-queue order SHALL be preserved; order between queues is not guaranteed, and the hazard unit stalls on busy to guarantee it.
REQ-019 Request with addr 0 SHALL be accepted (ready rules unchanged) but discarded: never queued, never asserts rf_we, never sets busy[0].
REQ-020 busy[r] SHALL be 1 iff a valid queue entry or the output stage (rf_we=1) holds addr r; combinational from registered state; busy[0] constant 0.
REQ-021 Queue read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit or occupancy counter.

Reset
REQ-022 Asserting reset (low) SHALL asynchronously clear both queues (empty), rf_we=0, rf_waddr=0, rf_wdata=0, last-grant=1 (so requester 0 wins first contention).
REQ-023 During reset wb0_ready=wb1_ready=0 and busy=0; ready SHALL rise only in the first cycle after reset deasserts.
REQ-024 Reset asserted mid-operation SHALL drop all pending and in-flight writes; no rf_we pulse SHALL occur during or immediately after reset.

Structure
REQ-025 Shared package rf_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, REG_ZERO=0 and the queue-entry struct {addr, data}.
REQ-026 Queue SHALL be one sub-module, wb_fifo (parameterised by FIFO_DEPTH), instantiated twice; arbitration, output stage and busy logic live in rf_write_arbiter.

Verification
REQ-027 Single write: wb0 {addr=5, data=0xDEADBEEF} accepted edge 1 -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF during cycle after edge 2 only; busy[5]=1 from edge 1 until rf_we drops.
REQ-028 Contention: both valid every cycle (wb0 addr 1,2,3; wb1 addr 9,10,11) -> rf_waddr sequence 1,9,2,10,3,11; no cycle with rf_we=0 between.
REQ-029 Backpressure: wb1 pushes 3 back-to-back with wb0 saturating, DEPTH=2 -> wb1_ready=0 after 2nd accept; 3rd accepted only after a wb1 pop; no entry lost or duplicated.
REQ-030 Zero register: wb0 {addr=0, data=0x1234} -> wb0_ready=1, no rf_we pulse, busy=0 throughout.
REQ-031 Reset mid-flight: 2 entries queued in each queue, reset pulsed low between edges -> rf_we=0 immediately, busy=0, both queues empty; first post-reset request written normally with 2-edge latency.
